// File: rtl/npc_pc_unit_if.sv
// npc_pc_unit_if: IF/ID-side bus of the PC unit.
//   master (hazard unit / ID stage): drives stall, NPCOp, PC4_D, Instr_D, RS_D, Equal.
//   slave  (npc_pc_unit): drives PC, PC4, PC8_D, Taken_D, PCOutOfRange
//   and, with NPC_ALIGN_CHECK_EN defined, AdEL_F.
interface npc_pc_unit_if;
   logic        stall;
   logic [2:0]  NPCOp;
   logic [31:0] PC4_D;
   logic [25:0] Instr_D;
   logic [31:0] RS_D;
   logic        Equal;
   logic [31:0] PC;
   logic [31:0] PC4;
   logic [31:0] PC8_D;
   logic        Taken_D;
   logic        PCOutOfRange;
`ifdef NPC_ALIGN_CHECK_EN
   logic        AdEL_F;
   modport master (output stall, NPCOp, PC4_D, Instr_D, RS_D, Equal,
                   input PC, PC4, PC8_D, Taken_D, PCOutOfRange, AdEL_F);
   modport slave (input stall, NPCOp, PC4_D, Instr_D, RS_D, Equal,
                  output PC, PC4, PC8_D, Taken_D, PCOutOfRange, AdEL_F);
`else
   modport master (output stall, NPCOp, PC4_D, Instr_D, RS_D, Equal,
                   input PC, PC4, PC8_D, Taken_D, PCOutOfRange);
   modport slave (input stall, NPCOp, PC4_D, Instr_D, RS_D, Equal,
                  output PC, PC4, PC8_D, Taken_D, PCOutOfRange);
`endif
endinterface

// File: rtl/npc_pc_unit.sv
// npc_pc_unit: IF-stage PC register with ID-stage next-PC resolution (one delay slot).
//   clk, reset (async, active-high) plain ports; everything else on bus (slave modport).
//   Inputs: stall, NPCOp (0 seq,1 beq,2 bne,3 j/jal,4 jr/jalr,5-7 seq), PC4_D, Instr_D, RS_D, Equal.
//   Outputs: PC, PC4, PC8_D (link), Taken_D, PCOutOfRange.
//   Optional macro NPC_ALIGN_CHECK_EN adds AdEL_F (fetch address misaligned).
module npc_pc_unit #(
   parameter logic [31:0] PC_RESET = 32'h0000_3000,
   parameter logic [31:0] IM_BASE  = 32'h0000_3000,
   parameter logic [31:0] IM_WORDS = 32'd4096
) (
   input logic          clk,
   input logic          reset,
   npc_pc_unit_if.slave bus
);
   localparam logic [31:0] IM_LAST = IM_BASE + (IM_WORDS << 2) - 32'd4;
   logic [31:0] pc_q, pc_plus4, br_target, j_target, npc;
   logic        br_taken;
   assign pc_plus4  = pc_q + 32'd4;
   assign br_target = bus.PC4_D + {{14{bus.Instr_D[15]}}, bus.Instr_D[15:0], 2'b00};
   assign j_target  = {bus.PC4_D[31:28], bus.Instr_D, 2'b00};
   assign br_taken  = (bus.NPCOp == 3'd1 && bus.Equal) || (bus.NPCOp == 3'd2 && !bus.Equal);
   // Taken_D reflects the selection, not whether the target differs from PC+4.
   assign bus.Taken_D = br_taken || bus.NPCOp == 3'd3 || bus.NPCOp == 3'd4;
   assign npc = bus.NPCOp == 3'd3 ? j_target :
                bus.NPCOp == 3'd4 ? bus.RS_D :
                br_taken          ? br_target : pc_plus4;
   // A stalled branch simply re-evaluates next cycle; nothing is latched, so reset drops it.
   always_ff @(posedge clk or posedge reset)
      if (reset) pc_q <= PC_RESET;
      else if (!bus.stall) pc_q <= npc;
   assign bus.PC           = pc_q;
   assign bus.PC4          = pc_plus4;
   assign bus.PC8_D        = bus.PC4_D + 32'd4;
   assign bus.PCOutOfRange = pc_q < IM_BASE || pc_q > IM_LAST;
`ifdef NPC_ALIGN_CHECK_EN
   assign bus.AdEL_F = |pc_q[1:0];
`endif
endmodule

// File: tb/tb_npc_pc_unit.sv
// tb_npc_pc_unit: directed scoreboard bench for npc_pc_unit.
module tb_npc_pc_unit;
   logic clk = 1'b0;
   logic reset = 1'b1;
   int vectors = 0;
   int miscompares = 0;
   logic [31:0] sb[$];
   npc_pc_unit_if bus();
   npc_pc_unit dut (.clk(clk), .reset(reset), .bus(bus));
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask
   // Drive one ID-stage op, check Taken_D, push expected PC, then check after the edge.
   task automatic step(input logic [2:0] op, input logic [31:0] pc4d, input logic [25:0] instr,
                       input logic [31:0] rs, input logic eq, input logic st,
                       input logic tk, input logic [31:0] exp_pc);
      logic [31:0] e;
      bus.NPCOp = op; bus.PC4_D = pc4d; bus.Instr_D = instr;
      bus.RS_D = rs; bus.Equal = eq; bus.stall = st;
      #1;
      chk("taken", {31'd0, bus.Taken_D}, {31'd0, tk});
      sb.push_back(exp_pc);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      chk("pc", bus.PC, e);
      chk("pc4", bus.PC4, e + 32'd4);
   endtask
   initial begin
      #100000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end
   initial begin
      bus.stall = 1'b0; bus.NPCOp = 3'd0; bus.PC4_D = 32'd0;
      bus.Instr_D = 26'd0; bus.RS_D = 32'd0; bus.Equal = 1'b0;
      #12;
      chk("rst_pc", bus.PC, 32'h3000);
      chk("rst_pc4", bus.PC4, 32'h3004);
      chk("rst_oor", {31'd0, bus.PCOutOfRange}, 32'd0);
      reset = 1'b0;
      step(3'd0, 32'h0, 26'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h3004);
      step(3'd0, 32'h0, 26'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h3008);
      step(3'd0, 32'h0, 26'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h300C);
      step(3'd1, 32'h3008, 26'h000FFFE, 32'h0, 1'b1, 1'b0, 1'b1, 32'h3000);
      step(3'd1, 32'h3008, 26'h000FFFE, 32'h0, 1'b0, 1'b0, 1'b0, 32'h3004);
      step(3'd2, 32'h3010, 26'h0000004, 32'h0, 1'b1, 1'b1, 1'b0, 32'h3004);
      step(3'd2, 32'h3010, 26'h0000004, 32'h0, 1'b1, 1'b1, 1'b0, 32'h3004);
      step(3'd2, 32'h3010, 26'h0000004, 32'h0, 1'b0, 1'b0, 1'b1, 32'h3020);
      bus.NPCOp = 3'd3; bus.PC4_D = 32'h3004; #1;
      chk("pc8_d", bus.PC8_D, 32'h3008);
      step(3'd3, 32'h3004, 26'h0000C10, 32'h0, 1'b0, 1'b0, 1'b1, 32'h3040);
      step(3'd4, 32'h3044, 26'h0, 32'h3100, 1'b0, 1'b0, 1'b1, 32'h3100);
      step(3'd4, 32'h3104, 26'h0, 32'h5000, 1'b0, 1'b1, 1'b1, 32'h3100);
      #2;
      reset = 1'b1;
      #1;
      chk("rst2_pc", bus.PC, 32'h3000);
      chk("rst2_pc4", bus.PC4, 32'h3004);
      chk("rst2_oor", {31'd0, bus.PCOutOfRange}, 32'd0);
      #1;
      reset = 1'b0;
      step(3'd0, 32'h0, 26'h0, 32'h5000, 1'b0, 1'b0, 1'b0, 32'h3004);
      step(3'd4, 32'h3008, 26'h0, 32'hFFFF_FFFC, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
      chk("oor_top", {31'd0, bus.PCOutOfRange}, 32'd1);
      step(3'd0, 32'h0, 26'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
      chk("oor_zero", {31'd0, bus.PCOutOfRange}, 32'd1);
      step(3'd4, 32'h0, 26'h0, 32'h6FFC, 1'b0, 1'b0, 1'b1, 32'h6FFC);
      chk("oor_last", {31'd0, bus.PCOutOfRange}, 32'd0);
      step(3'd4, 32'h7000, 26'h0, 32'h7000, 1'b0, 1'b0, 1'b1, 32'h7000);
      chk("oor_past", {31'd0, bus.PCOutOfRange}, 32'd1);
      step(3'd1, 32'h7000, 26'h0000001, 32'h0, 1'b1, 1'b0, 1'b1, 32'h7004);
      step(3'd5, 32'h0, 26'h0000C10, 32'h1234, 1'b1, 1'b0, 1'b0, 32'h7008);
      step(3'd7, 32'h0, 26'h0000C10, 32'h1234, 1'b0, 1'b0, 1'b0, 32'h700C);
      step(3'd2, 32'h0000_0004, 26'h000FFFC, 32'h0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFF4);
`ifdef NPC_ALIGN_CHECK_EN
      step(3'd4, 32'h0, 26'h0, 32'h3102, 1'b0, 1'b0, 1'b1, 32'h3102);
      chk("adel_set", {31'd0, bus.AdEL_F}, 32'd1);
      step(3'd4, 32'h0, 26'h0, 32'h3104, 1'b0, 1'b0, 1'b1, 32'h3104);
      chk("adel_clr", {31'd0, bus.AdEL_F}, 32'd0);
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/npc_pc_unit.md
Name: npc_pc_unit

Overview:
- IF-stage program counter register plus next-PC selection for the 5-stage MIPS pipeline.
- Consumes the ID-stage equality flag from the operand comparator, together with the ID-stage control and operands, and resolves beq/bne/j/jal/jr/jalr in ID.
- Branches use one delay slot: the instruction already fetched in IF is never squashed.
- Drives the instruction-memory address and the PC+4 value latched into the IF/ID register.

Parameters:
- PC_RESET, 32'h0000_3000, PC value loaded on reset.
- IM_BASE, 32'h0000_3000, lowest valid instruction address.
- IM_WORDS, 4096, instruction-memory depth in words; valid range is IM_BASE to IM_BASE+4*IM_WORDS-4.

Ports:
- clk, input, 1, pipeline clock; rising edge active.
- reset, input, 1, asynchronous, active-high reset.
- stall, input, 1, from the hazard unit; holds the PC register.
- NPCOp, input, 3, ID-stage next-PC op: 0 seq, 1 beq, 2 bne, 3 j/jal, 4 jr/jalr, 5-7 reserved.
- PC4_D, input, 32, PC+4 of the instruction in ID.
- Instr_D, input, 26, low 26 bits of the ID instruction (imm16 = [15:0], index = [25:0]).
- RS_D, input, 32, forwarded rs value for jr/jalr.
- Equal, input, 1, comparator result for the ID operands.
- PC, output, 32, current fetch address to the instruction memory.
- PC4, output, 32, PC+4 to the IF/ID register.
- PC8_D, output, 32, PC4_D+4; link value for jal/jalr.
- Taken_D, output, 1, asserted when the ID instruction redirects fetch.
- PCOutOfRange, output, 1, PC lies outside the instruction-memory range.

Behaviour:
- PC register:
  - reset asserted (asynchronously): PC <= PC_RESET.
  - Otherwise, on the rising edge of clk: if stall, PC holds; else PC <= NPC.
- Outputs while in reset: PC = PC_RESET, PC4 = PC_RESET+4, PCOutOfRange = 0. Taken_D and PC8_D remain combinational from their inputs.
- Reset deasserted mid-cycle: the first update occurs at the next rising edge. No pending redirect is retained across reset.
- NPC selection (combinational), all adds modulo 2^32:
  - NPCOp=0: NPC = PC+4.
  - NPCOp=1: taken = Equal.
  - NPCOp=2: taken = !Equal.
  - For op 1 and 2: NPC = taken ? PC4_D + (sext(imm16)<<2) : PC+4.
  - NPCOp=3: NPC = {PC4_D[31:28], index, 2'b00}; always taken.
  - NPCOp=4: NPC = RS_D unmodified; always taken.
  - NPCOp=5-7: treated as op 0; Taken_D = 0.
- Taken_D = 1 exactly when NPC is not PC+4 by selection. It is 1 even if the computed target equals PC+4.
- Delay slot: when the branch is in ID, the instruction in IF (at address PC4_D) completes normally. No flush output exists.
- Stall with a branch in ID: PC holds. The branch stays in ID and is re-evaluated the next cycle with updated forwarded Equal/RS_D. The redirect applies on the first unstalled edge only.
- Wrap-around: PC = 32'hFFFF_FFFC with op 0 gives NPC = 0. Negative branch offsets wrap naturally.
- PCOutOfRange = (PC < IM_BASE) || (PC > IM_BASE + 4*IM_WORDS - 4). Registered alongside PC; combinational decode of the registered PC is acceptable. Informational only; it has no effect on the update.
- Latency: a redirect resolved in ID at edge n appears on PC after edge n (one cycle).

Optional Feature:
- Macro: NPC_ALIGN_CHECK_EN.
- Defined:
  - Extra output port AdEL_F (1 bit) = 1 when PC[1:0] != 0.
  - When a jr/jalr target has RS_D[1:0] != 0, the PC still loads the value unmodified; AdEL_F flags it on the following cycle.
  - AdEL_F reset value 0.
- Undefined:
  - Port absent; misaligned jr targets load silently.
  - All other behaviour identical.

Test Plan:
- Reset: assert reset between edges -> PC = 32'h3000 immediately, PC4 = 32'h3004. Release, 3 unstalled edges with NPCOp=0 -> PC = 32'h300C.
- beq taken: PC4_D=32'h3008, imm16=16'hFFFE, Equal=1, NPCOp=1 -> Taken_D=1, next PC=32'h3000. Same with Equal=0 -> PC+4, Taken_D=0.
- bne plus stall: NPCOp=2, Equal=1 held with stall=1 for 2 cycles -> PC unchanged. Then Equal=0, stall=0, PC4_D=32'h3010, imm16=16'h0004 -> PC=32'h3020.
- j/jal and jr: PC4_D=32'h3004, index=26'h0000C10 -> PC=32'h3040, PC8_D=32'h3008. NPCOp=4, RS_D=32'h3100 -> PC=32'h3100.
- Boundaries:
  - Force PC=32'hFFFF_FFFC via jr, then op 0 -> PC=0.
  - PCOutOfRange=1 at both 32'hFFFF_FFFC and 0.
  - PCOutOfRange=0 at 32'h6FFC, =1 at 32'h7000 (defaults).
- NPC_ALIGN_CHECK_EN: jr to 32'h3102 -> PC=32'h3102, AdEL_F=1. Next jr to 32'h3104 -> AdEL_F=0. Without the macro the port does not exist and the bench skips this check.
